// File: rtl/dr_split_injector.sv
// ---------------------------------------------------------------------------
// dr_split_injector
//
// Clocked-to-asynchronous injector placed directly upstream of the router's
// PCHB split stage. Words arrive on a synchronous valid/ready port and are
// buffered in a small FIFO. Each word is then sent LSB-first as WIDTH
// four-phase return-to-zero dual-rail tokens on L. A matching dual-rail route
// token is sent on SELECT. The split's active-high enables Le/SELECTe act as
// the acknowledge and pass through SYNC_STAGES-deep synchronisers.
//
// Encoding: bit b -> L = {b, ~b}; dest 0 -> SELECT = 01, dest 1 -> SELECT = 10.
//
// Optional feature macro: DR_INJ_TIMEOUT_EN
//   When defined, a wait-state cycle counter sets the sticky err_timeout after
//   TIMEOUT cycles without progress. When undefined, err_timeout is always 0.
//
// Ports:
//   clk         clock
//   RESET       synchronous, active-high reset
//   in_valid    word offered
//   in_ready    FIFO can accept (registered, = !full)
//   in_data     WIDTH-bit payload
//   in_dest     route: 0 -> split output R0, 1 -> R1
//   L           dual-rail data token to split
//   Le          split data enable (high = request, low = acknowledged)
//   SELECT      dual-rail route token to split
//   SELECTe     split select enable
//   busy        FIFO non-empty or FSM not idle
//   words_sent  completed words, wraps at 16 bits
//   err_timeout sticky handshake timeout flag
// ---------------------------------------------------------------------------
module dr_split_injector #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dest,
    output logic [1:0]       L,
    input  logic             Le,
    output logic [1:0]       SELECT,
    input  logic             SELECTe,
    output logic             busy,
    output logic [15:0]      words_sent,
    output logic             err_timeout
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        WAIT_REQ = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_leSync;
    logic [SYNC_STAGES-1:0] r_selSync;
    logic                   w_leS;
    logic                   w_selS;

    logic [WIDTH:0]         r_mem [DEPTH];
    logic [PW-1:0]          r_wrPtr;
    logic [PW-1:0]          r_rdPtr;
    logic [CW-1:0]          r_count;
    logic [CW-1:0]          w_countNext;
    logic                   r_inReady;
    logic                   w_push;
    logic                   w_pop;
    logic [WIDTH:0]         w_head;

    state_t                 r_state;
    logic [WIDTH-1:0]       r_shift;
    logic                   r_dest;
    logic [IW-1:0]          r_bitIdx;
    logic [1:0]             r_L;
    logic [1:0]             r_select;
    logic [15:0]            r_wordsSent;
    logic                   w_advance;

    // Enables come from the asynchronous split, so both pass through
    // multi-flop synchronisers before the FSM looks at them.
    always_ff @(posedge clk) begin
        if (RESET) begin
            r_leSync  <= '0;
            r_selSync <= '0;
        end else begin
            r_leSync  <= {r_leSync[SYNC_STAGES-2:0], Le};
            r_selSync <= {r_selSync[SYNC_STAGES-2:0], SELECTe};
        end
    end

    assign w_leS  = r_leSync[SYNC_STAGES-1];
    assign w_selS = r_selSync[SYNC_STAGES-1];

    // in_ready comes from a flop, so a pop in the same cycle never frees a
    // slot for a push while full. There is no bypass: a word pushed into an
    // empty FIFO becomes poppable on the following cycle.
    assign w_push      = in_valid && r_inReady;
    assign w_pop       = (r_state == IDLE) && (r_count != '0) && w_leS && w_selS;
    assign w_countNext = r_count + CW'(w_push) - CW'(w_pop);
    assign w_head      = r_mem[r_rdPtr];

    // FIFO pointers, occupancy and the registered ready flag.
    always_ff @(posedge clk) begin
        if (RESET) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_count   <= '0;
            r_inReady <= 1'b1;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
            r_count   <= w_countNext;
            r_inReady <= (w_countNext != CW'(DEPTH));
        end
    end

    // FIFO storage holds {dest, data}. It needs no reset because the pointers
    // define which entries are live.
    always_ff @(posedge clk) begin
        if (!RESET && w_push) r_mem[r_wrPtr] <= {in_dest, in_data};
    end

    // The wait states finish only when both synchronised enables agree. If
    // only one enable has moved, the rails are held.
    assign w_advance = ((r_state == WAIT_ACK) && !w_leS && !w_selS) ||
                       ((r_state == WAIT_REQ) &&  w_leS &&  w_selS);

    // Token FSM. The rails are registered here, so L/SELECT only ever move
    // between 00 and a single valid code and never glitch.
    always_ff @(posedge clk) begin
        if (RESET) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_dest      <= 1'b0;
            r_bitIdx    <= '0;
            r_L         <= 2'b00;
            r_select    <= 2'b00;
            r_wordsSent <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_shift  <= w_head[WIDTH-1:0];
                        r_dest   <= w_head[WIDTH];
                        r_bitIdx <= '0;
                        r_L      <= {w_head[0], ~w_head[0]};
                        r_select <= w_head[WIDTH] ? 2'b10 : 2'b01;
                        r_state  <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (w_advance) begin
                        r_L      <= 2'b00;
                        r_select <= 2'b00;
                        r_state  <= WAIT_REQ;
                    end
                end
                WAIT_REQ: begin
                    if (w_advance) begin
                        if (r_bitIdx == IW'(WIDTH - 1)) begin
                            r_wordsSent <= r_wordsSent + 16'd1;
                            r_state     <= IDLE;
                        end else begin
                            // The shift register keeps the current bit in
                            // position 0, so position 1 holds the next bit.
                            r_bitIdx <= r_bitIdx + 1'b1;
                            r_shift  <= r_shift >> 1;
                            r_L      <= {r_shift[1], ~r_shift[1]};
                            r_select <= r_dest ? 2'b10 : 2'b01;
                            r_state  <= WAIT_ACK;
                        end
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_L      <= 2'b00;
                    r_select <= 2'b00;
                end
            endcase
        end
    end

`ifdef DR_INJ_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [TW-1:0] r_waitCnt;
    logic          r_errTimeout;

    // The counter restarts on every state change. It saturates at TIMEOUT so
    // a long stall cannot wrap it. The flag is only reported; the FSM keeps
    // waiting.
    always_ff @(posedge clk) begin
        if (RESET) begin
            r_waitCnt    <= '0;
            r_errTimeout <= 1'b0;
        end else begin
            if ((r_state == IDLE) || w_advance)
                r_waitCnt <= '0;
            else if (r_waitCnt != TW'(TIMEOUT))
                r_waitCnt <= r_waitCnt + 1'b1;
            if ((r_state != IDLE) && !w_advance && (r_waitCnt == TW'(TIMEOUT - 1)))
                r_errTimeout <= 1'b1;
        end
    end

    assign err_timeout = r_errTimeout;
`else
    // Without the timeout feature this is constant 0 for any legal TIMEOUT.
    assign err_timeout = (TIMEOUT < 0);
`endif

    assign in_ready   = r_inReady;
    assign L          = r_L;
    assign SELECT     = r_select;
    assign words_sent = r_wordsSent;
    assign busy       = (r_state != IDLE) || (r_count != '0);

endmodule

// File: doc/dr_split_injector.md
Name: dr_split_injector

Overview:
- Clocked-to-asynchronous injector that sits directly upstream of the PCHB split stage in the router.
- Accepts WIDTH-bit words with a 1-bit destination over a synchronous valid/ready port and buffers them in a DEPTH-entry FIFO.
- Serialises each word LSB-first into 4-phase return-to-zero dual-rail tokens on L, with a matching dual-rail route token on SELECT.
- Uses the split's active-high enables Le/SELECTe as the acknowledge.

Parameters:
WIDTH, 8, data bits per word (tokens per word)
DEPTH, 4, FIFO entries; power of two, >=2
SYNC_STAGES, 2, flops in each Le/SELECTe synchroniser, >=2
TIMEOUT, 255, cycles allowed in a wait state before flagging (feature only)

Ports:
clk  input  1  clock
RESET  input  1  reset
in_valid  input  1  word offered
in_ready  output  1  FIFO can accept (= !full, registered)
in_data  input  WIDTH  payload
in_dest  input  1  0 -> split output R0, 1 -> split output R1
L  output  2  dual-rail data token to split
Le  input  1  split data enable; high = request, low = acknowledged
SELECT  output  2  dual-rail route token to split
SELECTe  input  1  split select enable
busy  output  1  FIFO non-empty or FSM not IDLE
words_sent  output  16  completed words, wraps 0xFFFF -> 0
err_timeout  output  1  sticky handshake timeout flag

Behaviour:
- Reset: RESET is synchronous, active-high. On the next clk edge:
  - L=00, SELECT=00, FIFO emptied, in_ready=1, busy=0, words_sent=0, err_timeout=0.
  - Synchroniser flops are cleared to 0; state = IDLE.
  - Reset mid-token is identical: rails drop to 00 on the next edge and nothing is resumed.
- Encoding: bit b -> L={b,~b}; dest 0 -> SELECT=01, dest 1 -> SELECT=10.
- Rail/handshake rules:
  - L and SELECT are driven only from flops.
  - Only transitions allowed: 00 -> valid, or valid -> 00.
  - Both rails never high together.
- le_s and sele_s are the synchronised Le and SELECTe.
- FIFO:
  - Push when in_valid && in_ready.
  - in_ready is derived from the registered count, so there is no push when full, even if a pop happens the same cycle.
  - No bypass: a word pushed into an empty FIFO is poppable from the following cycle.
- FSM states and transitions:
  - IDLE:
    - If FIFO non-empty && le_s && sele_s: pop the head into shift reg and dest reg, bit_idx=0.
    - Drive L/SELECT with bit 0 on the same edge; go to WAIT_ACK.
  - WAIT_ACK:
    - Hold rails until le_s==0 && sele_s==0.
    - Then drive L=00, SELECT=00; go to WAIT_REQ.
    - Only one enable low: keep holding.
  - WAIT_REQ:
    - Wait for le_s==1 && sele_s==1.
    - If bit_idx==WIDTH-1: words_sent++, go to IDLE.
    - Otherwise bit_idx++, drive the next bit with the same SELECT, go to WAIT_ACK.
- Latency:
  - A word present in the FIFO with enables high gets its rails valid 1 cycle after the pop decision.
  - Each token phase is at least SYNC_STAGES+1 cycles after the corresponding enable edge.
- Back-to-back words: IDLE re-checks the FIFO on the cycle after WAIT_REQ completes. No token is ever skipped or duplicated.
- busy: high whenever state != IDLE or count != 0.

Optional Feature:
Macro DR_INJ_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT_ACK and WAIT_REQ and clears on every state change.
  - On reaching TIMEOUT it sets err_timeout, which stays set until RESET.
  - The FSM keeps waiting and does not abort.
- Undefined: no counter is instantiated and err_timeout is tied 0.

Test Plan:
- RESET high 2 cycles, then low -> L=00, SELECT=00, in_ready=1, busy=0, words_sent=0, err_timeout=0.
- Push in_data=8'hA5, in_dest=0, with a responder dropping both enables 3 cycles after valid and raising them 3 cycles after null:
  - L sequence is 10,01,10,01,01,10,01,10, with 00 between tokens.
  - SELECT=01 on every token.
  - words_sent=1, busy=0 at the end.
- Push 8'h3C with in_dest=1 -> SELECT=10 on all 8 tokens; L rails are 01 for bits 0,1,6,7 and 10 for bits 2-5.
- Hold Le low and push 5 words (DEPTH=4):
  - No pop occurs; in_ready=0 after the 4th push and the 5th word stalls.
  - Release Le -> all 5 words are delivered in order.
- During a token, lower only Le -> rails held, no null phase. Lower SELECTe 4 cycles later -> null phase follows within SYNC_STAGES+1 cycles.
- Assert RESET during WAIT_ACK with 2 words queued -> rails=00 on the next edge, FIFO empty, words_sent=0.
  - With DR_INJ_TIMEOUT_EN and TIMEOUT=16, freeze both enables high after a token is driven -> err_timeout=1 exactly 16 cycles into WAIT_ACK, and it stays set.
